// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared write-back select codes, LSU state encoding and default width
package cpu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_DRAM = 2'b01;
    localparam logic [1:0] WD_PC4  = 2'b10;
    localparam logic [1:0] WD_IMM  = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUS  = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - req/ack data bus between the memory stage and data memory
interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage_lsu_wb_data_mux.sv
// rtl/mem_stage_lsu_wb_data_mux.sv - 4:1 write-back data select (ALU, load data, pc+4, imm)
module wb_data_mux
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [1:0]      wd_sel,
    input  logic [XLEN-1:0] alu,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] wd
);

    // pick the value the instruction writes back to the register file
    always_comb begin
        wd = alu;
        case (wd_sel)
            WD_DRAM: wd = rdata;
            WD_PC4:  wd = pc + XLEN'(4);
            WD_IMM:  wd = imm;
            default: wd = alu;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory stage with bus FSM and MEM/WB register; MEM_TIMEOUT_EN adds a bus timeout
module mem_stage_lsu
    import cpu_pkg::*;
#(
    parameter int              XLEN           = XLEN_DEF,
    parameter int              TIMEOUT_CYCLES = 255,
    parameter logic [XLEN-1:0] RESET_PC       = 32'hffff_fffc
) (
    input  logic              clk_cpu,
    input  logic              rst_cpu,
    input  logic [XLEN-1:0]   addr_mem,
    input  logic              rd_we_mem,
    input  logic              dram_we_mem,
    input  logic [1:0]        wd_sel_mem,
    input  logic [4:0]        rd_mem,
    input  logic [XLEN-1:0]   rD2_mem,
    input  logic [XLEN-1:0]   imm_mem,
    input  logic [XLEN-1:0]   pc_mem,
    input  logic              flag_mem,
    output logic              stall_mem,
    mem_stage_lsu_if.master   dbus,
    output logic              rd_we_wb,
    output logic [4:0]        rd_wb,
    output logic [XLEN-1:0]   wD_wb,
    output logic [XLEN-1:0]   pc_wb,
    output logic              flag_wb,
    output logic              misalign_wb,
    output logic              bus_err_wb
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_BUS  = BUS;

    logic [0:0]      state;
    logic            memop;
    logic            misalign;
    logic            rd_we_eff;
    logic            expire;
    logic            capture;
    logic [XLEN-1:0] wd_next;

    assign memop     = dram_we_mem | (wd_sel_mem == WD_DRAM);
    assign misalign  = memop & (addr_mem[1:0] != 2'b00);
    assign rd_we_eff = rd_we_mem & (rd_mem != 5'd0);
    // an instruction retires into MEM/WB either straight from IDLE or on the bus ack
    assign capture   = ((state == ST_IDLE) & ~memop) | ((state == ST_BUS) & dbus.ack);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] to_cnt;

    // ack in the expiry cycle takes priority, so expiry requires no ack
    assign expire = (state == ST_BUS) & ~dbus.ack & (to_cnt == CW'(TIMEOUT_CYCLES));

    // counts BUS cycles without ack; held at zero in IDLE so it starts fresh on BUS entry
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu || state == ST_IDLE) begin
            to_cnt <= '0;
        end else if (!dbus.ack && !expire) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign expire     = 1'b0;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    wb_data_mux #(.XLEN(XLEN)) u_wb_mux (
        .wd_sel (wd_sel_mem),
        .alu    (addr_mem),
        .rdata  (dbus.rdata),
        .pc     (pc_mem),
        .imm    (imm_mem),
        .wd     (wd_next)
    );

    // hold the front of the pipe until the bus op for the current instruction resolves
    always_comb begin
        stall_mem = 1'b0;
        if (!rst_cpu) begin
            if (state == ST_IDLE) begin
                stall_mem = memop;
            end else begin
                stall_mem = ~dbus.ack & ~expire;
            end
        end
    end

    // bus FSM: launch a word access from IDLE, keep it stable until ack or timeout
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            state      <= ST_IDLE;
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            dbus.addr  <= '0;
            dbus.wdata <= '0;
        end else if (state == ST_IDLE) begin
            if (memop) begin
                state      <= ST_BUS;
                dbus.req   <= 1'b1;
                dbus.we    <= dram_we_mem;
                dbus.addr  <= {addr_mem[XLEN-1:2], 2'b00};
                dbus.wdata <= rD2_mem;
            end
        end else if (dbus.ack || expire) begin
            state    <= ST_IDLE;
            dbus.req <= 1'b0;
        end
    end

    // MEM/WB register: retire, abort with bus error, or insert a bubble
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            rd_we_wb    <= 1'b0;
            rd_wb       <= 5'd0;
            wD_wb       <= '0;
            pc_wb       <= RESET_PC;
            flag_wb     <= 1'b0;
            misalign_wb <= 1'b0;
            bus_err_wb  <= 1'b0;
        end else if (capture) begin
            rd_we_wb    <= rd_we_eff;
            rd_wb       <= rd_mem;
            wD_wb       <= wd_next;
            pc_wb       <= pc_mem;
            flag_wb     <= flag_mem;
            misalign_wb <= misalign;
            bus_err_wb  <= 1'b0;
        end else if (expire) begin
            rd_we_wb    <= 1'b0;
            rd_wb       <= rd_mem;
            pc_wb       <= pc_mem;
            flag_wb     <= flag_mem;
            misalign_wb <= misalign;
            bus_err_wb  <= 1'b1;
        end else begin
            rd_we_wb    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized bench for mem_stage_lsu against a word-memory reference model
module tb_mem_stage_lsu;

    localparam int          TO       = 4;
    localparam logic [31:0] RST_PC   = 32'hffff_fffc;

    logic        clk_cpu = 1'b0;
    logic        rst_cpu;
    logic [31:0] addr_mem;
    logic        rd_we_mem;
    logic        dram_we_mem;
    logic [1:0]  wd_sel_mem;
    logic [4:0]  rd_mem;
    logic [31:0] rD2_mem;
    logic [31:0] imm_mem;
    logic [31:0] pc_mem;
    logic        flag_mem;
    logic        stall_mem;
    logic        rd_we_wb;
    logic [4:0]  rd_wb;
    logic [31:0] wD_wb;
    logic [31:0] pc_wb;
    logic        flag_wb;
    logic        misalign_wb;
    logic        bus_err_wb;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [int unsigned];

    mem_stage_lsu_if #(.XLEN(32)) dbus_if ();

    mem_stage_lsu #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (TO),
        .RESET_PC       (RST_PC)
    ) dut (
        .clk_cpu     (clk_cpu),
        .rst_cpu     (rst_cpu),
        .addr_mem    (addr_mem),
        .rd_we_mem   (rd_we_mem),
        .dram_we_mem (dram_we_mem),
        .wd_sel_mem  (wd_sel_mem),
        .rd_mem      (rd_mem),
        .rD2_mem     (rD2_mem),
        .imm_mem     (imm_mem),
        .pc_mem      (pc_mem),
        .flag_mem    (flag_mem),
        .stall_mem   (stall_mem),
        .dbus        (dbus_if),
        .rd_we_wb    (rd_we_wb),
        .rd_wb       (rd_wb),
        .wD_wb       (wD_wb),
        .pc_wb       (pc_wb),
        .flag_wb     (flag_wb),
        .misalign_wb (misalign_wb),
        .bus_err_wb  (bus_err_wb)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] waddr);
        if (mem.exists(waddr)) return mem[waddr];
        return waddr ^ 32'h5a5a_0f0f;
    endfunction

    task automatic set_nop();
        addr_mem    = 32'h0;
        rd_we_mem   = 1'b0;
        dram_we_mem = 1'b0;
        wd_sel_mem  = 2'b00;
        rd_mem      = 5'd0;
        rD2_mem     = 32'h0;
        imm_mem     = 32'h0;
        pc_mem      = 32'h0;
        flag_mem    = 1'b0;
    endtask

    // Called just after a falling edge. dly < 0 means the bus never acks.
    task automatic run_instr(input string tag, input logic [31:0] addr, input logic rd_we,
                             input logic dram_we, input logic [1:0] wd_sel, input logic [4:0] rd,
                             input logic [31:0] rd2, input logic [31:0] imm, input logic [31:0] pc,
                             input logic flag, input int dly);
        logic        memop, is_load, timed_out;
        logic [31:0] waddr, exp_wd, load_val;
        int          exp_stalls, stalls, pulses, reqs, bus_bad;
        bit          done;

        memop     = dram_we || (wd_sel == 2'b01);
        is_load   = memop && !dram_we;
        timed_out = memop && (dly < 0);
        waddr     = {addr[31:2], 2'b00};
        load_val  = mem_rd(waddr);
        case (wd_sel)
            2'b00:   exp_wd = addr;
            2'b01:   exp_wd = load_val;
            2'b10:   exp_wd = pc + 32'd4;
            default: exp_wd = imm;
        endcase
        exp_stalls = !memop ? 0 : (timed_out ? 1 + TO : 1 + dly);

        addr_mem = addr; rd_we_mem = rd_we; dram_we_mem = dram_we; wd_sel_mem = wd_sel;
        rd_mem = rd; rD2_mem = rd2; imm_mem = imm; pc_mem = pc; flag_mem = flag;

        done = 0; stalls = 0; pulses = 0; reqs = 0; bus_bad = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (dbus_if.req) begin
                reqs++;
                if (dbus_if.addr !== waddr || dbus_if.we !== dram_we ||
                    (dram_we && dbus_if.wdata !== rd2))
                    bus_bad++;
                if (dly >= 0 && reqs == dly + 1) begin
                    dbus_if.ack   = 1'b1;
                    dbus_if.rdata = is_load ? load_val : $urandom;
                    if (dram_we) mem[waddr] = rd2;
                end
            end
            #1;
            if (stall_mem) stalls++;
            else done = 1;
            @(posedge clk_cpu);
            #1;
            dbus_if.ack   = 1'b0;
            dbus_if.rdata = $urandom;
            if (rd_we_wb) pulses++;
            @(negedge clk_cpu);
        end

        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stalls"}, stalls, exp_stalls);
        chk({tag, "_reqs"}, reqs, !memop ? 0 : (timed_out ? TO + 1 : dly + 1));
        chk({tag, "_bus_stable"}, bus_bad, 0);
        chk({tag, "_pulses"}, pulses, (!timed_out && rd_we && rd != 5'd0) ? 1 : 0);
        chk({tag, "_rd_we_wb"}, 32'(rd_we_wb), (!timed_out && rd_we && rd != 5'd0) ? 1 : 0);
        chk({tag, "_rd_wb"}, 32'(rd_wb), 32'(rd));
        if (!timed_out) chk({tag, "_wD_wb"}, wD_wb, exp_wd);
        chk({tag, "_pc_wb"}, pc_wb, pc);
        chk({tag, "_flag_wb"}, 32'(flag_wb), 32'(flag));
        chk({tag, "_misalign"}, 32'(misalign_wb), 32'(memop && addr[1:0] != 2'b00));
        chk({tag, "_bus_err"}, 32'(bus_err_wb), 32'(timed_out));
        chk({tag, "_req_after"}, 32'(dbus_if.req), 32'd0);

        set_nop();
        @(negedge clk_cpu);
    endtask

    initial begin
        logic [1:0]  wsel;
        logic [31:0] a;
        int          kind;

        set_nop();
        dbus_if.ack   = 1'b0;
        dbus_if.rdata = 32'h0;
        rst_cpu       = 1'b1;
        wd_sel_mem    = 2'b01;
        repeat (3) @(negedge clk_cpu);
        chk("rst_stall", 32'(stall_mem), 32'd0);
        chk("rst_req", 32'(dbus_if.req), 32'd0);
        chk("rst_pc_wb", pc_wb, RST_PC);
        chk("rst_rd_we_wb", 32'(rd_we_wb), 32'd0);
        chk("rst_wD_wb", wD_wb, 32'd0);
        chk("rst_bus_err", 32'(bus_err_wb), 32'd0);
        set_nop();
        rst_cpu = 1'b0;
        @(negedge clk_cpu);

        run_instr("t1_alu",   32'h10,  1, 0, 2'b00, 5'd5, 32'h0,  32'h0, 32'h40, 1'b1, 0);
        run_instr("t2_load",  32'h100, 1, 0, 2'b01, 5'd7, 32'h0,  32'h0, 32'h44, 1'b0, 3);
        mem[32'h100] = 32'hDEADBEEF;
        run_instr("t2b_load", 32'h100, 1, 0, 2'b01, 5'd8, 32'h0,  32'h0, 32'h48, 1'b0, 3);
        run_instr("t3_store", 32'h204, 0, 1, 2'b00, 5'd0, 32'h55, 32'h0, 32'h4c, 1'b0, 2);
        run_instr("t4_mis",   32'h102, 1, 0, 2'b01, 5'd9, 32'h0,  32'h0, 32'h50, 1'b1, 0);
        run_instr("t_pc4",    32'h7,   1, 0, 2'b10, 5'd1, 32'h0,  32'h0, 32'h54, 1'b0, 0);
        run_instr("t_imm_r0", 32'h7,   1, 0, 2'b11, 5'd0, 32'h0,  32'h1234, 32'h58, 1'b0, 0);

        // reset in the middle of a bus op, then a late ack must be ignored
        addr_mem = 32'h300; rd_we_mem = 1'b1; wd_sel_mem = 2'b01; rd_mem = 5'd3; pc_mem = 32'h60;
        @(posedge clk_cpu); #1;
        chk("t5_req_before", 32'(dbus_if.req), 32'd1);
        @(negedge clk_cpu);
        rst_cpu = 1'b1;
        #1;
        chk("t5_stall_in_rst", 32'(stall_mem), 32'd0);
        @(posedge clk_cpu); #1;
        chk("t5_req", 32'(dbus_if.req), 32'd0);
        chk("t5_pc_wb", pc_wb, RST_PC);
        chk("t5_rd_we_wb", 32'(rd_we_wb), 32'd0);
        chk("t5_rd_wb", 32'(rd_wb), 32'd0);
        chk("t5_wD_wb", wD_wb, 32'd0);
        @(negedge clk_cpu);
        rst_cpu = 1'b0;
        set_nop();
        dbus_if.ack = 1'b1;
        #1;
        chk("t5_late_ack_stall", 32'(stall_mem), 32'd0);
        @(posedge clk_cpu); #1;
        dbus_if.ack = 1'b0;
        chk("t5_late_ack_req", 32'(dbus_if.req), 32'd0);
        chk("t5_late_ack_we", 32'(rd_we_wb), 32'd0);
        @(negedge clk_cpu);

`ifdef MEM_TIMEOUT_EN
        run_instr("t6_timeout", 32'h400, 1, 0, 2'b01, 5'd4, 32'h0, 32'h0, 32'h70, 1'b0, -1);
        run_instr("t6_after",   32'h400, 1, 0, 2'b01, 5'd4, 32'h0, 32'h0, 32'h74, 1'b0, 1);
`endif

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            wsel = 2'($urandom_range(0, 2));
            if (wsel == 2'b01) wsel = 2'b11;
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (kind == 0) a = $urandom;
            run_instr($sformatf("rnd%0d", n), a, 1'($urandom), (kind == 2),
                      (kind == 1) ? 2'b01 : wsel, 5'($urandom_range(0, 31)),
                      $urandom, $urandom, $urandom, 1'($urandom), $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
